// File: rtl/vip_stream_select_pkg.sv
// Shared constants for the camera-to-UDP stream selector: default widths,
// IR remote key codes and the channel-select FSM state type.
package vip_stream_select_pkg;

    localparam int DEF_PIX_W  = 16;
    localparam int DEF_BYTE_W = 8;
    localparam int DEF_CODE_W = 8;

    localparam logic [7:0] KEY_RAW   = 8'h0d;
    localparam logic [7:0] KEY_VIP   = 8'h16;
    localparam logic [7:0] KEY_SOBEL = 8'h19;
    localparam logic [7:0] KEY_BIN   = 8'h0c;
    localparam logic [7:0] KEY_ROT   = 8'h18;

    // Entry i (bits i*8+:8) selects channel i: raw, vip, sobel, bin, rotate.
    localparam logic [39:0] DEF_CODE_TABLE = {KEY_ROT, KEY_BIN, KEY_SOBEL, KEY_VIP, KEY_RAW};

    typedef enum logic {
        SEL_IDLE = 1'b0,
        SEL_PEND = 1'b1
    } sel_state_e;

    function automatic int unsigned bytes_per_pixel(input int unsigned pix_w,
                                                    input int unsigned byte_w);
        return pix_w / byte_w;
    endfunction

endpackage

// File: rtl/vip_stream_select_serializer.sv
// Pixel-to-byte serializer: loads a PIX_W pixel on i_load and emits it
// MSB byte first, one byte per cycle, with a sticky overrun flag.
module vip_byte_serializer
    import vip_stream_select_pkg::*;
#(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int BYTE_W = DEF_BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [PIX_W-1:0]  i_pixel,
    output logic              o_de,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_overrun
);

    localparam int NB    = int'(bytes_per_pixel(PIX_W, BYTE_W));
    localparam int CNT_W = $clog2(NB + 1);

    logic [PIX_W-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             r_overrun;

    // A load while more than the current byte remains discards the remainder;
    // a load during the last-byte cycle is the legal back-to-back case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_pixel;
            r_cnt   <= CNT_W'(NB);
            if (r_cnt > CNT_W'(1)) begin
                r_overrun <= 1'b1;
            end
        end else if (r_cnt != '0) begin
            r_shift <= r_shift << BYTE_W;
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    assign o_de      = (r_cnt != '0);
    assign o_data    = o_de ? r_shift[PIX_W-1 -: BYTE_W] : '0;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/vip_stream_select.sv
// N-channel pixel-stream selector: IR key code to channel lookup, switching
// only at frame starts, with byte serialization and matching sync delay.
module vip_stream_select
    import vip_stream_select_pkg::*;
#(
    parameter int                       CH_NUM     = 5,
    parameter int                       PIX_W      = DEF_PIX_W,
    parameter int                       BYTE_W     = DEF_BYTE_W,
    parameter int                       CODE_W     = DEF_CODE_W,
    parameter logic [CH_NUM*CODE_W-1:0] CODE_TABLE = DEF_CODE_TABLE,
    parameter int                       DEF_CH     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CODE_W-1:0]         sel_code,
    input  logic [CH_NUM-1:0]         ch_vsync,
    input  logic [CH_NUM-1:0]         ch_href,
    input  logic [CH_NUM-1:0]         ch_de,
    input  logic [CH_NUM*PIX_W-1:0]   ch_data,
    output logic                      out_vsync,
    output logic                      out_href,
    output logic                      out_de,
    output logic [BYTE_W-1:0]         out_data,
    output logic [$clog2(CH_NUM)-1:0] active_ch,
    output logic                      switch_pend,
    output logic                      overrun_err
);

    localparam int                NB      = int'(bytes_per_pixel(PIX_W, BYTE_W));
    localparam int                CH_W    = $clog2(CH_NUM);
    localparam logic [CH_W-1:0]   DEF_IDX = CH_W'(DEF_CH);

    sel_state_e        r_state;
    sel_state_e        w_state_nxt;
    logic [CH_W-1:0]   r_req_ch;
    logic [CH_W-1:0]   r_active_ch;
    logic [CH_W-1:0]   w_lookup_ch;
    logic [CH_W-1:0]   w_active_nxt;
    logic [CH_NUM-1:0] r_vsync_prev;
    logic [NB-1:0]     r_vs_dly;
    logic [NB-1:0]     r_hr_dly;

    logic              w_sel_vsync;
    logic              w_sel_vsync_prev;
    logic              w_sel_href;
    logic              w_sel_de;
    logic [PIX_W-1:0]  w_sel_pixel;
    logic              w_req_href;
    logic              w_vsync_rise;

    // Lowest matching table entry wins; unmatched codes fall back to DEF_CH.
    always_comb begin
        w_lookup_ch = DEF_IDX;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (CODE_TABLE[i*CODE_W +: CODE_W] == sel_code) begin
                w_lookup_ch = CH_W'(i);
            end
        end
    end

    always_comb begin
        w_sel_vsync      = 1'b0;
        w_sel_vsync_prev = 1'b0;
        w_sel_href       = 1'b0;
        w_sel_de         = 1'b0;
        w_sel_pixel      = '0;
        w_req_href       = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (r_active_ch == CH_W'(i)) begin
                w_sel_vsync      = ch_vsync[i];
                w_sel_vsync_prev = r_vsync_prev[i];
                w_sel_href       = ch_href[i];
                w_sel_de         = ch_de[i];
                w_sel_pixel      = ch_data[i*PIX_W +: PIX_W];
            end
            if (r_req_ch == CH_W'(i)) begin
                w_req_href = ch_href[i];
            end
        end
    end

    assign w_vsync_rise = w_sel_vsync & ~w_sel_vsync_prev;

    // PEND means the registered request differs from the active channel; the
    // switch lands on the active channel's frame start if the target is idle.
    always_comb begin
        w_active_nxt = r_active_ch;
        w_state_nxt  = r_state;
        case (r_state)
            SEL_PEND: begin
                if (w_vsync_rise && !w_req_href) begin
                    w_active_nxt = r_req_ch;
                end
            end
            default: begin
                w_active_nxt = r_active_ch;
            end
        endcase
        w_state_nxt = (w_lookup_ch != w_active_nxt) ? SEL_PEND : SEL_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SEL_IDLE;
            r_req_ch     <= DEF_IDX;
            r_active_ch  <= DEF_IDX;
            r_vsync_prev <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_ch     <= w_lookup_ch;
            r_active_ch  <= w_active_nxt;
            r_vsync_prev <= ch_vsync;
        end
    end

    // Sync delay matches the serializer so syncs frame the last byte of a pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_dly <= '0;
            r_hr_dly <= '0;
        end else begin
            r_vs_dly[0] <= w_sel_vsync;
            r_hr_dly[0] <= w_sel_href;
            for (int k = 1; k < NB; k++) begin
                r_vs_dly[k] <= r_vs_dly[k-1];
                r_hr_dly[k] <= r_hr_dly[k-1];
            end
        end
    end

    vip_byte_serializer #(
        .PIX_W  (PIX_W),
        .BYTE_W (BYTE_W)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_sel_de),
        .i_pixel   (w_sel_pixel),
        .o_de      (out_de),
        .o_data    (out_data),
        .o_overrun (overrun_err)
    );

    assign out_vsync   = r_vs_dly[NB-1];
    assign out_href    = r_hr_dly[NB-1];
    assign active_ch   = r_active_ch;
    assign switch_pend = (r_state == SEL_PEND);

endmodule

// File: tb/tb_vip_stream_select.sv
// Randomized bench for vip_stream_select with a queue-based reference model,
// plus directed frame-switch, overrun, reset and 24-bit pixel scenarios.
module tb_vip_stream_select;

    localparam int CH = 5;
    localparam int PW = 16;
    localparam int NB = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        sel_code;
    logic [CH-1:0]     ch_vsync, ch_href, ch_de;
    logic [CH*PW-1:0]  ch_data;
    logic              out_vsync, out_href, out_de;
    logic [7:0]        out_data;
    logic [2:0]        active_ch;
    logic              switch_pend, overrun_err;

    logic [CH-1:0]     v24, h24, d24;
    logic [CH*24-1:0]  dat24;
    logic              o24_vsync, o24_href, o24_de;
    logic [7:0]        o24_data;
    logic [2:0]        o24_active;
    logic              o24_pend, o24_ovr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vip_stream_select #(.CH_NUM(CH), .PIX_W(PW), .BYTE_W(8), .CODE_W(8), .DEF_CH(1)) dut (
        .clk(clk), .rst_n(rst_n), .sel_code(sel_code),
        .ch_vsync(ch_vsync), .ch_href(ch_href), .ch_de(ch_de), .ch_data(ch_data),
        .out_vsync(out_vsync), .out_href(out_href), .out_de(out_de), .out_data(out_data),
        .active_ch(active_ch), .switch_pend(switch_pend), .overrun_err(overrun_err)
    );

    vip_stream_select #(.CH_NUM(CH), .PIX_W(24), .BYTE_W(8), .CODE_W(8), .DEF_CH(1)) dut24 (
        .clk(clk), .rst_n(rst_n), .sel_code(sel_code),
        .ch_vsync(v24), .ch_href(h24), .ch_de(d24), .ch_data(dat24),
        .out_vsync(o24_vsync), .out_href(o24_href), .out_de(o24_de), .out_data(o24_data),
        .active_ch(o24_active), .switch_pend(o24_pend), .overrun_err(o24_ovr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] codes [CH] = '{8'h0d, 8'h16, 8'h19, 8'h0c, 8'h18};
    int         m_req, m_act;
    logic [CH-1:0] m_prev_vs;
    logic [7:0] m_q[$];
    logic       m_ovr;
    logic       m_vs_hist[$];
    logic       m_hr_hist[$];

    function automatic int lookup(input logic [7:0] c);
        for (int i = 0; i < CH; i++) begin
            if (codes[i] == c) return i;
        end
        return 1;
    endfunction

    task automatic m_reset();
        m_req = 1;
        m_act = 1;
        m_prev_vs = '0;
        m_ovr = 1'b0;
        m_q.delete();
        m_vs_hist.delete();
        m_hr_hist.delete();
        for (int k = 0; k < NB; k++) begin
            m_vs_hist.push_back(1'b0);
            m_hr_hist.push_back(1'b0);
        end
    endtask

    task automatic m_step();
        logic [PW-1:0] px;
        px = ch_data[m_act*PW +: PW];
        if (ch_de[m_act]) begin
            if (m_q.size() > 1) m_ovr = 1'b1;
            m_q.delete();
            m_q.push_back(px[15:8]);
            m_q.push_back(px[7:0]);
        end else if (m_q.size() > 0) begin
            void'(m_q.pop_front());
        end
        m_vs_hist.push_back(ch_vsync[m_act]);
        m_hr_hist.push_back(ch_href[m_act]);
        void'(m_vs_hist.pop_front());
        void'(m_hr_hist.pop_front());
        if (ch_vsync[m_act] && !m_prev_vs[m_act] && !ch_href[m_req]) m_act = m_req;
        m_prev_vs = ch_vsync;
        m_req = lookup(sel_code);
    endtask

    task automatic compare();
        chk("active_ch", 32'(active_ch), 32'(m_act));
        chk("switch_pend", 32'(switch_pend), 32'(m_req != m_act));
        chk("out_de", 32'(out_de), 32'(m_q.size() != 0));
        chk("out_data", 32'(out_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
        chk("overrun_err", 32'(overrun_err), 32'(m_ovr));
        chk("out_vsync", 32'(out_vsync), 32'(m_vs_hist[0]));
        chk("out_href", 32'(out_href), 32'(m_hr_hist[0]));
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
            #2;
            compare();
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic zero_inputs();
        ch_vsync = '0; ch_href = '0; ch_de = '0; ch_data = '0;
    endtask

    initial begin
        logic [7:0] pool [6];
        pool = '{8'h0d, 8'h16, 8'h19, 8'h0c, 8'h18, 8'h77};
        sel_code = 8'h77;
        zero_inputs();
        v24 = '0; h24 = '0; d24 = '0; dat24 = '0;
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        @(posedge clk); #3;
        chk("rst_active_ch", 32'(active_ch), 32'd1);
        chk("rst_switch_pend", 32'(switch_pend), 32'd0);
        chk("rst_out_de", 32'(out_de), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_overrun", 32'(overrun_err), 32'd0);

        // First pixel on the default channel.
        cyc(); ch_de[1] = 1'b1; ch_data[PW +: PW] = 16'hABCD;
        cyc(); ch_de = '0;
        chk("abcd_b0_de", 32'(out_de), 32'd1);
        chk("abcd_b0", 32'(out_data), 32'hAB);
        cyc();
        chk("abcd_b1_de", 32'(out_de), 32'd1);
        chk("abcd_b1", 32'(out_data), 32'hCD);
        cyc();
        chk("abcd_done", 32'(out_de), 32'd0);

        // 24-bit build: three bytes, href lags by three cycles.
        d24[1] = 1'b1; dat24[24 +: 24] = 24'h123456; h24[1] = 1'b1;
        cyc(); d24 = '0;
        chk("p24_b0", 32'(o24_data), 32'h12);
        chk("p24_href1", 32'(o24_href), 32'd0);
        cyc();
        chk("p24_b1", 32'(o24_data), 32'h34);
        chk("p24_href2", 32'(o24_href), 32'd0);
        cyc();
        chk("p24_b2", 32'(o24_data), 32'h56);
        chk("p24_de", 32'(o24_de), 32'd1);
        chk("p24_href3", 32'(o24_href), 32'd1);
        cyc();
        chk("p24_done", 32'(o24_de), 32'd0);
        h24 = '0;

        // Mid-frame request waits for the frame boundary.
        ch_href[1] = 1'b1; sel_code = 8'h16;
        cyc(); sel_code = 8'h19;
        cyc(); cyc();
        chk("sw_pend", 32'(switch_pend), 32'd1);
        chk("sw_hold", 32'(active_ch), 32'd1);
        ch_vsync[2] = 1'b1;
        cyc();
        chk("sw_other_vs", 32'(active_ch), 32'd1);
        ch_href[1] = 1'b0; ch_href[2] = 1'b1; ch_vsync[1] = 1'b1;
        cyc();
        chk("sw_tgt_busy", 32'(active_ch), 32'd1);
        ch_vsync[1] = 1'b0;
        cyc();
        ch_href[2] = 1'b0; ch_vsync[1] = 1'b1;
        cyc();
        chk("sw_done_ch", 32'(active_ch), 32'd2);
        chk("sw_done_pend", 32'(switch_pend), 32'd0);

        // Latest request wins at the boundary.
        ch_vsync = '0; ch_href[2] = 1'b1; sel_code = 8'h16;
        cyc(); sel_code = 8'h18;
        cyc();
        chk("latest_hold", 32'(active_ch), 32'd2);
        chk("latest_pend", 32'(switch_pend), 32'd1);
        ch_href = '0; ch_vsync[2] = 1'b1;
        cyc();
        chk("latest_ch", 32'(active_ch), 32'd4);
        ch_vsync = '0;
        cyc();

        // Overrun: every other cycle is legal, back-to-back is not.
        for (int k = 0; k < 4; k++) begin
            ch_de[4] = 1'b1; ch_data[4*PW +: PW] = PW'($urandom);
            cyc(); ch_de = '0;
            cyc();
        end
        chk("ovr_legal", 32'(overrun_err), 32'd0);
        ch_de[4] = 1'b1;
        cyc(); cyc(); ch_de = '0;
        cyc();
        chk("ovr_set", 32'(overrun_err), 32'd1);
        repeat (4) cyc();
        chk("ovr_sticky", 32'(overrun_err), 32'd1);

        // Asynchronous reset in the middle of a pixel.
        ch_de[4] = 1'b1; ch_data[4*PW +: PW] = 16'h1234;
        cyc(); ch_de = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_de", 32'(out_de), 32'd0);
        chk("arst_ch", 32'(active_ch), 32'd1);
        chk("arst_ovr", 32'(overrun_err), 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc(); ch_de[1] = 1'b1; ch_data[PW +: PW] = 16'h5A3C;
        cyc(); ch_de = '0;
        chk("post_rst_b0", 32'(out_data), 32'h5A);
        cyc();
        chk("post_rst_b1", 32'(out_data), 32'h3C);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (n == 1500) rst_n = 1'b0;
            if (n == 1502) rst_n = 1'b1;
            if ($urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 6) == 6) sel_code = 8'($urandom);
                else sel_code = pool[$urandom_range(0, 5)];
            end
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 39) == 0) ch_vsync[c] = ~ch_vsync[c];
                if ($urandom_range(0, 5) == 0) ch_href[c] = ~ch_href[c];
                ch_de[c] = ($urandom_range(0, 2) == 0);
                ch_data[c*PW +: PW] = PW'($urandom);
            end
        end
        cyc();
        zero_inputs();
        repeat (5) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
